// File: rtl/lenet_pkg.sv
// Shared LeNet definitions: layer sizes, data width and the pooling controller state encoding.
package lenet_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned F4_W   = 10;
    localparam int unsigned F5_W   = 5;

    typedef enum logic [2:0] {
        StIdle = 3'b001,
        StRun  = 3'b010,
        StDone = 3'b100
    } pool_state_e;

endpackage

// File: rtl/pool_max2x2.sv
// Registered signed running maximum over one 2x2 window; strobes a write after the last element.
module pool_max2x2 #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned AW     = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_vld,
    input  logic              i_first,
    input  logic              i_last,
    input  logic [AW-1:0]     i_addr,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_wr_en,
    output logic [AW-1:0]     o_waddr,
    output logic [DATA_W-1:0] o_wdata
);

    logic signed [DATA_W-1:0] r_max;
    logic                     r_wr_en;
    logic [AW-1:0]            r_waddr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_max   <= '0;
            r_wr_en <= 1'b0;
            r_waddr <= '0;
        end else begin
            // Strict compare: a tie leaves the held maximum untouched.
            if (i_vld && (i_first || ($signed(i_data) > r_max))) begin
                r_max <= i_data;
            end
            r_wr_en <= i_vld & i_last;
            if (i_vld && i_last) begin
                r_waddr <= i_addr;
            end
        end
    end

    assign o_wr_en = r_wr_en;
    assign o_waddr = r_waddr;
    assign o_wdata = r_max;

endmodule

// File: rtl/pool2_ctrl.sv
// 2x2 stride-2 max pooling of F4 into F5: window counters, address pipeline, tag delay lines.
module pool2_ctrl
    import lenet_pkg::*;
#(
    parameter int unsigned DATA_W = lenet_pkg::DATA_W,
    parameter int unsigned IN_W   = F4_W,
    parameter int unsigned F4_AW  = 7,
    parameter int unsigned F5_AW  = 5,
    parameter int unsigned RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pool2_start,
    output logic [F4_AW-1:0]  f4_raddr,
    output logic              f4_rd_en,
    input  logic [DATA_W-1:0] f4_rdata,
    output logic [F5_AW-1:0]  f5_waddr,
    output logic [DATA_W-1:0] f5_wdata,
    output logic              f5_wr_en,
    output logic              pool2_done
);

    localparam int unsigned   OUT_W = IN_W / 2;
    localparam int unsigned   CW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam logic [CW-1:0] CMAX  = CW'(OUT_W - 1);

    typedef struct packed {
        logic             vld;
        logic             first;
        logic             last;
        logic [F5_AW-1:0] oaddr;
    } tag_t;

    pool_state_e      r_state;
    logic             r_c0;
    logic             r_c1;
    logic [CW-1:0]    r_c2;
    logic [CW-1:0]    r_c3;
    logic             w_run;
    logic             w_last_cnt;
    logic [F5_AW-1:0] w_oaddr;

    assign w_run      = (r_state == StRun);
    assign w_last_cnt = r_c0 & r_c1 & (r_c2 == CMAX) & (r_c3 == CMAX);
    assign w_oaddr    = F5_AW'(OUT_W) * F5_AW'(r_c3) + F5_AW'(r_c2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_c0    <= 1'b0;
            r_c1    <= 1'b0;
            r_c2    <= '0;
            r_c3    <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (pool2_start) begin
                        r_state <= StRun;
                    end
                end
                StRun: begin
                    r_c0 <= ~r_c0;
                    if (r_c0) begin
                        r_c1 <= ~r_c1;
                        if (r_c1) begin
                            r_c2 <= (r_c2 == CMAX) ? '0 : r_c2 + CW'(1);
                            if (r_c2 == CMAX) begin
                                r_c3 <= (r_c3 == CMAX) ? '0 : r_c3 + CW'(1);
                            end
                        end
                    end
                    if (w_last_cnt) begin
                        r_state <= StDone;
                    end
                end
                StDone:  r_state <= StIdle;
                default: r_state <= StIdle;
            endcase
        end
    end

    logic [F4_AW-1:0] r_s1_row;
    logic [F4_AW-1:0] r_s1_col;
    tag_t             r_s1_tag;
    logic [F4_AW-1:0] r_f4_raddr;
    tag_t             r_s2_tag;
    tag_t             r_dl [RD_LAT];
    logic [RD_LAT+2:0] r_done_dl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_row   <= '0;
            r_s1_col   <= '0;
            r_s1_tag   <= '0;
            r_f4_raddr <= '0;
            r_s2_tag   <= '0;
            r_done_dl  <= '0;
            for (int i = 0; i < int'(RD_LAT); i++) begin
                r_dl[i] <= '0;
            end
        end else begin
            r_s1_row       <= F4_AW'({r_c3, r_c1});
            r_s1_col       <= F4_AW'({r_c2, r_c0});
            r_s1_tag.vld   <= w_run;
            r_s1_tag.first <= ~r_c0 & ~r_c1;
            r_s1_tag.last  <= r_c0 & r_c1;
            r_s1_tag.oaddr <= w_oaddr;
            // row*IN_W as row*8 + row*2 for the 10-wide F4 map.
            r_f4_raddr <= (r_s1_row << 3) + (r_s1_row << 1) + r_s1_col;
            r_s2_tag   <= r_s1_tag;
            r_dl[0]    <= r_s2_tag;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                r_dl[i] <= r_dl[i-1];
            end
            r_done_dl <= {r_done_dl[RD_LAT+1:0], (r_state == StDone)};
        end
    end

    tag_t w_tag_al;
    assign w_tag_al = r_dl[RD_LAT-1];

    pool_max2x2 #(
        .DATA_W (DATA_W),
        .AW     (F5_AW)
    ) u_max (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_vld   (w_tag_al.vld),
        .i_first (w_tag_al.first),
        .i_last  (w_tag_al.last),
        .i_addr  (w_tag_al.oaddr),
        .i_data  (f4_rdata),
        .o_wr_en (f5_wr_en),
        .o_waddr (f5_waddr),
        .o_wdata (f5_wdata)
    );

    assign f4_raddr   = r_f4_raddr;
    assign f4_rd_en   = r_s2_tag.vld;
    assign pool2_done = r_done_dl[RD_LAT+2];

endmodule
